// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified instruction/data memory arbiter.
package mem_arb_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StBusyI,
        StBusyD,
        StDoneI,
        StDoneD
    } arb_state_e;

    localparam logic [31:0] ABORT_DATA      = 32'hDEADBEEF;
    localparam int unsigned BURST_LIMIT_DEF = 4;
    localparam int unsigned TIMEOUT_DEF     = 15;

endpackage

// File: rtl/arb_timer.sv
// Busy-cycle timer: counts cycles without a memory ack and flags the cycle that
// would make the count reach TIMEOUT.
module arb_timer #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int unsigned   TW   = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TOP  = TW'(TIMEOUT);

    logic [TW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && count_q != TOP) begin
            count_d = count_q + 1'b1;
        end
    end

    // This cycle's increment would reach TIMEOUT.
    assign expire = enable && (count_q == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and the data
// port; data wins, bounded by a burst limit, with a per-transaction timeout.
module unified_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW          = 32,
    parameter int unsigned DW          = 32,
    parameter int unsigned BURST_LIMIT = BURST_LIMIT_DEF,
    parameter int unsigned TIMEOUT     = TIMEOUT_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ready,
    input  logic          d_rd,
    input  logic          d_wr,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ready,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          bus_err
);

    localparam int unsigned   BW        = $clog2(BURST_LIMIT + 1);
    localparam logic [BW-1:0] BURST_MAX = BW'(BURST_LIMIT);

    arb_state_e    state_q, state_d;
    logic [BW-1:0] burst_q, burst_d;
    logic          mem_en_d, mem_we_d, if_ready_d, d_ready_d, bus_err_d;
    logic [AW-1:0] mem_addr_d;
    logic [DW-1:0] mem_wdata_d, if_rdata_d, d_rdata_d, resp_data;
    logic          d_req, burst_ok, busy, expire;

    assign d_req     = d_rd | d_wr;
    assign burst_ok  = burst_q < BURST_MAX;
    assign busy      = (state_q == StBusyI) || (state_q == StBusyD);
    assign resp_data = mem_ack ? mem_rdata : DW'(ABORT_DATA);

    arb_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .clear (!busy),
        .enable(busy && !mem_ack),
        .expire(expire)
    );

    always_comb begin
        state_d     = state_q;
        burst_d     = burst_q;
        mem_en_d    = mem_en;
        mem_we_d    = mem_we;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        if_rdata_d  = if_rdata;
        d_rdata_d   = d_rdata;
        if_ready_d  = 1'b0;
        d_ready_d   = 1'b0;
        bus_err_d   = bus_err;

        unique case (state_q)
            StIdle: begin
                if (!if_req) begin
                    burst_d = '0;
                end
                if (d_req && (!if_req || burst_ok)) begin
                    state_d     = StBusyD;
                    mem_en_d    = 1'b1;
                    mem_we_d    = d_wr;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    // Data only wins below the limit, so this cannot overflow.
                    if (if_req) begin
                        burst_d = burst_q + 1'b1;
                    end
                end else if (if_req) begin
                    state_d     = StBusyI;
                    mem_en_d    = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = d_wdata;
                    burst_d     = '0;
                end
            end
            StBusyI, StBusyD: begin
                if (mem_ack || expire) begin
                    mem_en_d = 1'b0;
                    if (!mem_ack) begin
                        bus_err_d = 1'b1;
                    end
                    if (state_q == StBusyI) begin
                        if_rdata_d = resp_data;
                        if_ready_d = 1'b1;
                        state_d    = StDoneI;
                    end else begin
                        d_rdata_d = resp_data;
                        d_ready_d = 1'b1;
                        state_d   = StDoneD;
                    end
                end
            end
            StDoneI, StDoneD: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            burst_q   <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            if_ready  <= 1'b0;
            d_ready   <= 1'b0;
            bus_err   <= 1'b0;
        end else begin
            state_q   <= state_d;
            burst_q   <= burst_d;
            mem_en    <= mem_en_d;
            mem_we    <= mem_we_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            if_rdata  <= if_rdata_d;
            d_rdata   <= d_rdata_d;
            if_ready  <= if_ready_d;
            d_ready   <= d_ready_d;
            bus_err   <= bus_err_d;
        end
    end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: directed scenarios plus randomized requesters,
// checked against a transaction-level model of the arbitration rules.
module tb_unified_mem_arbiter;

    localparam int unsigned TO = 15;
    localparam int unsigned BL = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, if_ready, d_rd, d_wr, d_ready;
    logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata;
    logic        mem_en, mem_we, mem_ack, bus_err;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: burst run length, sticky error, last word returned per port.
    int          m_burst;
    bit          m_err;
    logic [31:0] m_if, m_d;

    unified_mem_arbiter #(
        .AW(32), .DW(32), .BURST_LIMIT(BL), .TIMEOUT(TO)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_rdata (if_rdata),
        .if_ready (if_ready),
        .d_rd     (d_rd),
        .d_wr     (d_wr),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_rdata  (d_rdata),
        .d_ready  (d_ready),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ack  (mem_ack),
        .bus_err  (bus_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_burst = 0;
        m_err   = 1'b0;
        m_if    = '0;
        m_d     = '0;
    endtask

    // Runs one arbitration decision from an idle cycle whose inputs are already set.
    // lat: BUSY cycle carrying the ack (beyond TO means never). won/obs: 0 none, 1 I, 2 D.
    task automatic step(input int lat, input logic [31:0] rd, input bit drop,
                        output int won, output int obs);
        bit          dp, ip, abort;
        int          k;
        bit          exp_we;
        logic [31:0] exp_addr, exp_wd, exp_rd;
        dp = d_rd | d_wr;
        ip = if_req;
        if (dp && (!ip || m_burst < int'(BL))) won = 2;
        else if (ip) won = 1;
        else won = 0;
        if (!ip || won == 1) m_burst = 0;
        else if (won == 2) m_burst = m_burst + 1;
        obs = 0;
        if (won == 0) begin
            tick();
            check_eq("idle_mem_en", mem_en, 0);
            check_eq("idle_ready", {if_ready, d_ready}, 0);
            check_eq("idle_bus_err", bus_err, m_err);
            return;
        end
        exp_addr = (won == 2) ? d_addr : if_addr;
        exp_we   = (won == 2) && d_wr;
        exp_wd   = d_wdata;
        tick();
        check_eq("grant_en", mem_en, 1);
        check_eq("grant_we", mem_we, exp_we);
        check_eq("grant_addr", mem_addr, exp_addr);
        check_eq("grant_wdata", mem_wdata, exp_wd);
        obs   = (mem_addr[31:16] == 16'h1000) ? 1 : 2;
        abort = lat > int'(TO);
        k     = abort ? int'(TO) : lat;
        for (int j = 1; j <= k; j++) begin
            if (j > 1) begin
                check_eq("busy_en", mem_en, 1);
                check_eq("busy_hold", {mem_we, mem_addr, mem_wdata}, {exp_we, exp_addr, exp_wd});
                check_eq("busy_ready", {if_ready, d_ready}, 0);
            end
            if (drop && j == 2 && won == 2) begin
                d_rd = 1'b0;
                d_wr = 1'b0;
            end
            mem_ack   = (j == lat);
            mem_rdata = (j == lat) ? rd : $urandom;
            tick();
        end
        mem_ack = 1'b0;
        exp_rd  = abort ? 32'hDEADBEEF : rd;
        if (abort) m_err = 1'b1;
        if (won == 1) m_if = exp_rd;
        else m_d = exp_rd;
        check_eq("done_if_ready", if_ready, won == 1);
        check_eq("done_d_ready", d_ready, won == 2);
        check_eq("done_if_rdata", if_rdata, m_if);
        check_eq("done_d_rdata", d_rdata, m_d);
        check_eq("done_mem_en", mem_en, 0);
        check_eq("done_bus_err", bus_err, m_err);
        tick();
        check_eq("post_ready", {if_ready, d_ready}, 0);
        check_eq("post_mem_en", mem_en, 0);
    endtask

    initial begin
        int won, obs, lat, pat[10];
        bit drop;
        pat = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1};

        reset = 1'b1;
        if_req = 0; if_addr = '0; d_rd = 0; d_wr = 0; d_addr = '0; d_wdata = '0;
        mem_ack = 0; mem_rdata = '0;
        model_reset();
        #2;
        check_eq("rst_mem", {mem_en, mem_we, mem_addr, mem_wdata}, 0);
        check_eq("rst_rdata", {if_rdata, d_rdata}, 0);
        check_eq("rst_flags", {if_ready, d_ready, bus_err}, 0);
        #10 reset = 1'b0;
        tick();

        // Single fetch with first-cycle ack.
        if_req = 1; if_addr = 32'h40;
        step(1, 32'h8C220004, 0, won, obs);
        check_eq("fetch_won", won, 1);
        if_req = 0;

        // Simultaneous: data first, fetch right after.
        if_req = 1; if_addr = 32'h1000_0080;
        d_wr = 1; d_addr = 32'h100; d_wdata = 32'h12345678;
        step(2, 32'h0, 0, won, obs);
        check_eq("simul_first", obs, 2);
        d_wr = 0;
        step(1, 32'h11112222, 0, won, obs);
        check_eq("simul_second", obs, 1);
        if_req = 0;

        // Starvation guard with both ports requesting continuously.
        step(1, 32'h0, 0, won, obs);
        if_req = 1; if_addr = 32'h1000_0010;
        d_rd = 1; d_addr = 32'h2000_0020;
        for (int i = 0; i < 10; i++) begin
            step(1, $urandom, 0, won, obs);
            check_eq("starve_seq", obs, pat[i]);
        end
        if_req = 0; d_rd = 0;

        // Ack on the final allowed cycle wins over the timeout.
        d_rd = 1; d_addr = 32'h204;
        step(15, 32'hCAFEF00D, 0, won, obs);
        check_eq("late_ack_err", bus_err, 0);
        // No ack at all: abort.
        d_addr = 32'h200;
        step(20, 32'h0, 0, won, obs);
        check_eq("timeout_data", d_rdata, 32'hDEADBEEF);
        d_rd = 0;
        step(1, 32'h0, 0, won, obs);
        check_eq("err_sticky", bus_err, 1);

        // Asynchronous reset in the middle of a write.
        d_wr = 1; d_addr = 32'h300; d_wdata = 32'hA5A5A5A5;
        tick();
        check_eq("rstw_grant", {mem_en, mem_we}, 2'b11);
        tick();
        #3 reset = 1'b1;
        #1;
        check_eq("rstw_mem_en", mem_en, 0);
        check_eq("rstw_flags", {d_ready, bus_err}, 0);
        d_wr = 0;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        tick();
        check_eq("rstw_no_ready", {if_ready, d_ready, mem_en}, 0);
        d_rd = 1; d_addr = 32'h304;
        step(3, 32'h0BADF00D, 0, won, obs);
        check_eq("rstw_fresh", won, 2);
        d_rd = 0;

        // Write request dropped mid-transaction still completes.
        d_wr = 1; d_addr = 32'h400; d_wdata = 32'h55AA55AA;
        step(5, 32'h0, 1, won, obs);
        check_eq("drop_inputs", {d_rd, d_wr}, 0);

        // Randomized requesters.
        won = 0;
        for (int it = 0; it < 400; it++) begin
            if (won == 1) begin
                if ($urandom_range(0, 99) < 70) if_addr = {16'h1000, 16'($urandom) & 16'hFFFC};
                else if_req = 0;
            end else if (!if_req && $urandom_range(0, 99) < 60) begin
                if_req  = 1;
                if_addr = {16'h1000, 16'($urandom) & 16'hFFFC};
            end
            if (won == 2 && $urandom_range(0, 99) >= 70) begin
                d_rd = 0;
                d_wr = 0;
            end else if (won == 2 || (!(d_rd | d_wr) && $urandom_range(0, 99) < 60)) begin
                case ($urandom_range(0, 2))
                    0: begin d_rd = 1; d_wr = 0; end
                    1: begin d_rd = 0; d_wr = 1; end
                    default: begin d_rd = 1; d_wr = 1; end
                endcase
                d_addr  = {16'h2000, 16'($urandom) & 16'hFFFC};
                d_wdata = $urandom;
            end
            lat  = ($urandom_range(0, 19) == 0) ? int'($urandom_range(14, 17))
                                                : int'($urandom_range(1, 4));
            drop = ($urandom_range(0, 9) == 0);
            step(lat, $urandom, drop, won, obs);
            if (won != 0) check_eq("rand_port", obs, won);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
